// File: rtl/spi_tx_scheduler.sv
// Round-robin transmit scheduler for the SPI slave byte sender.
// Frames each granted word as header, payload (MSB first) and XOR checksum, one byte per byte_sent.
module spi_tx_scheduler #(
    parameter int          NUM_CH     = 4,
    parameter int          WORD_BYTES = 2,
    parameter logic [7:0]  HEADER     = 8'hA0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req,
    input  logic [NUM_CH*8*WORD_BYTES-1:0] req_data,
    output logic [NUM_CH-1:0]              ack,
    output logic [7:0]                     tx_data,
    input  logic                           byte_sent,
    output logic                           link_enable,
    output logic                           busy,
    output logic [15:0]                    frame_count
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHK} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [W-1:0]      word_q, word_d;
    logic [BW-1:0]     idx_q, idx_d;
    logic              link_enable_q;

    logic [W-1:0]      words [NUM_CH];
    logic              grant_valid;
    logic [CW-1:0]     grant_idx;
    logic [7:0]        grant_hdr;
    logic              last_byte;
    int                cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_words
            assign words[gi] = req_data[gi*W +: W];
        end
    endgenerate

    // Rotating priority: scan downward so the candidate closest to ptr_q is written last and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = CW'(cand);
            end
        end
    end

    assign grant_hdr = {HEADER[7:4], 4'(grant_idx)};
    assign last_byte = (idx_q == BW'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (byte_sent) begin
            case (state_q)
                S_IDLE:  state_d = grant_valid ? S_HDR : S_IDLE;
                S_HDR:   state_d = S_PAY;
                S_PAY:   state_d = last_byte ? S_CHK : S_PAY;
                S_CHK:   state_d = grant_valid ? S_HDR : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_data_d     = tx_data_q;
        csum_d        = csum_q;
        word_d        = word_q;
        idx_d         = idx_q;
        ptr_d         = ptr_q;
        ack_d         = '0;
        frame_count_d = frame_count_q;
        if (byte_sent) begin
            case (state_q)
                S_IDLE, S_CHK: begin
                    if (state_q == S_CHK) begin
                        frame_count_d = frame_count_q + 16'd1;
                    end
                    // Granting from CHK loads the next header directly, so no filler byte appears.
                    if (grant_valid) begin
                        tx_data_d        = grant_hdr;
                        csum_d           = grant_hdr;
                        word_d           = words[grant_idx];
                        ack_d[grant_idx] = 1'b1;
                        ptr_d            = (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                    end else begin
                        tx_data_d = 8'h00;
                    end
                end
                S_HDR: begin
                    tx_data_d = word_q[W-1 -: 8];
                    csum_d    = csum_q ^ word_q[W-1 -: 8];
                    word_d    = word_q << 8;
                    idx_d     = '0;
                end
                S_PAY: begin
                    if (last_byte) begin
                        tx_data_d = csum_q;
                    end else begin
                        tx_data_d = word_q[W-1 -: 8];
                        csum_d    = csum_q ^ word_q[W-1 -: 8];
                        word_d    = word_q << 8;
                        idx_d     = idx_q + 1'b1;
                    end
                end
                default: begin
                    tx_data_d = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q     <= 8'h00;
            csum_q        <= 8'h00;
            word_q        <= '0;
            idx_q         <= '0;
            ptr_q         <= '0;
            ack_q         <= '0;
            frame_count_q <= 16'd0;
            link_enable_q <= 1'b0;
        end else begin
            tx_data_q     <= tx_data_d;
            csum_q        <= csum_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
            ack_q         <= ack_d;
            frame_count_q <= frame_count_d;
            link_enable_q <= 1'b1;
        end
    end

    assign tx_data     = tx_data_q;
    assign ack         = ack_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_count = frame_count_q;
    assign link_enable = link_enable_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Randomized and directed bench for spi_tx_scheduler against a queue-based frame model.
module tb_spi_tx_scheduler;

    localparam int NUM_CH     = 4;
    localparam int WORD_BYTES = 2;
    localparam int W          = 8 * WORD_BYTES;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_CH-1:0]     req = '0;
    logic [NUM_CH*W-1:0]   req_data = '0;
    logic                  byte_sent = 1'b0;
    logic [NUM_CH-1:0]     ack;
    logic [7:0]            tx_data;
    logic                  link_enable;
    logic                  busy;
    logic [15:0]           frame_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: bytes still owed for the frame in flight, arbitration pointer, completed frames.
    logic [7:0] m_q[$];
    int         m_ptr      = 0;
    logic       m_in_frame = 1'b0;
    int         m_count    = 0;

    spi_tx_scheduler #(
        .NUM_CH(NUM_CH),
        .WORD_BYTES(WORD_BYTES),
        .HEADER(8'hA0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .tx_data(tx_data),
        .byte_sent(byte_sent),
        .link_enable(link_enable),
        .busy(busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    function automatic void model_reset();
        m_q.delete();
        m_ptr      = 0;
        m_in_frame = 1'b0;
        m_count    = 0;
    endfunction

    task automatic model_step(input logic [NUM_CH-1:0] r, input logic [NUM_CH*W-1:0] d,
                              output logic [7:0] e_tx, output logic [NUM_CH-1:0] e_ack,
                              output int win);
        logic [7:0] h, cs, bt;
        logic [W-1:0] wd;
        e_tx  = 8'h00;
        e_ack = '0;
        win   = -1;
        if (m_in_frame && m_q.size() > 0) begin
            e_tx = m_q.pop_front();
        end else begin
            if (m_in_frame) m_count++;
            m_in_frame = 1'b0;
            for (int k = 0; k < NUM_CH; k++)
                if (win < 0 && r[(m_ptr + k) % NUM_CH]) win = (m_ptr + k) % NUM_CH;
            if (win >= 0) begin
                h  = 8'hA0 | 8'(win);
                cs = h;
                wd = d[win*W +: W];
                m_q.push_back(h);
                for (int b = WORD_BYTES - 1; b >= 0; b--) begin
                    bt = wd[b*8 +: 8];
                    cs = cs ^ bt;
                    m_q.push_back(bt);
                end
                m_q.push_back(cs);
                e_tx       = m_q.pop_front();
                e_ack[win] = 1'b1;
                m_ptr      = (win + 1) % NUM_CH;
                m_in_frame = 1'b1;
            end
        end
    endtask

    // One byte_sent pulse; samples outputs the cycle after the edge and ack one cycle later.
    task automatic send_byte(output logic [7:0] tx, output logic [NUM_CH-1:0] a0,
                             output logic [NUM_CH-1:0] a1, output logic b, output logic [15:0] fc);
        @(negedge clk);
        byte_sent = 1'b1;
        @(negedge clk);
        byte_sent = 1'b0;
        tx = tx_data;
        a0 = ack;
        b  = busy;
        fc = frame_count;
        @(negedge clk);
        a1 = ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] tx;
        logic [NUM_CH-1:0] a0, a1;
        logic b;
        logic [15:0] fc;
        @(negedge clk);
        total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx: got %h required 00", tx_data); else pass_cnt++;
        total_cnt++; if (ack !== '0) $display("FAIL reset_ack: got %b required 0000", ack); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (frame_count !== 16'd0) $display("FAIL reset_fc: got %0d required 0", frame_count); else pass_cnt++;
        total_cnt++; if (link_enable !== 1'b0) $display("FAIL reset_link: got %b required 0", link_enable); else pass_cnt++;
        rst = 1'b0;
        model_reset();
        #1;
        total_cnt++; if (link_enable !== 1'b0) $display("FAIL link_before_edge: got %b required 0", link_enable); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (link_enable !== 1'b1) $display("FAIL link_after_edge: got %b required 1", link_enable); else pass_cnt++;

        req = 4'b0001;
        req_data[15:0] = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            send_byte(tx, a0, a1, b, fc);
            if (a0[0]) req[0] = 1'b0;
        end
        total_cnt++; if (fc !== 16'd1) $display("FAIL prereset_fc: got %0d required 1", fc); else pass_cnt++;
        req[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_byte(tx, a0, a1, b, fc);
            if (a0[0]) req[0] = 1'b0;
        end
        total_cnt++; if (b !== 1'b1) $display("FAIL prereset_busy: got %b required 1", b); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (tx_data !== 8'h00) $display("FAIL midrun_reset_tx: got %h required 00", tx_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrun_reset_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (frame_count !== 16'd0) $display("FAIL midrun_reset_fc: got %0d required 0", frame_count); else pass_cnt++;
        total_cnt++; if (link_enable !== 1'b0) $display("FAIL midrun_reset_link: got %b required 0", link_enable); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total_cnt++; if (link_enable !== 1'b1) $display("FAIL relink: got %b required 1", link_enable); else pass_cnt++;
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_tx [5] = '{8'hA2, 8'h12, 8'h34, 8'h84, 8'h00};
        logic [7:0] tx;
        logic [NUM_CH-1:0] a0, a1, e_ack;
        logic b;
        logic [15:0] fc;
        do_reset();
        req = 4'b0100;
        req_data = '0;
        req_data[47:32] = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            send_byte(tx, a0, a1, b, fc);
            if (a0[2]) req[2] = 1'b0;
            e_ack = (i == 0) ? 4'b0100 : 4'b0000;
            $display("single byte %0d: tx=%h ack=%b", i, tx, a0);
            total_cnt++; if (tx !== exp_tx[i]) $display("FAIL single_tx[%0d]: got %h required %h", i, tx, exp_tx[i]); else pass_cnt++;
            total_cnt++; if (a0 !== e_ack) $display("FAIL single_ack[%0d]: got %b required %b", i, a0, e_ack); else pass_cnt++;
            total_cnt++; if (a1 !== 4'b0000) $display("FAIL single_ack_width[%0d]: got %b required 0000", i, a1); else pass_cnt++;
        end
        total_cnt++; if (fc !== 16'd1) $display("FAIL single_fc: got %0d required 1", fc); else pass_cnt++;
        total_cnt++; if (b !== 1'b0) $display("FAIL single_busy: got %b required 0", b); else pass_cnt++;
    endtask

    task automatic test_all_four();
        logic [7:0] tx, e_tx;
        logic [NUM_CH-1:0] a0, a1, e_ack;
        logic b;
        logic [15:0] fc;
        int win;
        do_reset();
        req = 4'b1111;
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 17; i++) begin
            model_step(req, req_data, e_tx, e_ack, win);
            send_byte(tx, a0, a1, b, fc);
            if (win >= 0) req[win] = 1'b0;
            $display("all4 byte %0d: tx=%h ack=%b", i, tx, a0);
            total_cnt++; if (tx !== e_tx) $display("FAIL all4_tx[%0d]: got %h required %h", i, tx, e_tx); else pass_cnt++;
            total_cnt++; if (a0 !== e_ack) $display("FAIL all4_ack[%0d]: got %b required %b", i, a0, e_ack); else pass_cnt++;
            if (i % 4 == 0 && i < 16) begin
                total_cnt++;
                if (tx !== 8'(8'hA0 + i / 4)) $display("FAIL all4_hdr[%0d]: got %h required %h", i, tx, 8'(8'hA0 + i / 4));
                else pass_cnt++;
            end
        end
        total_cnt++; if (fc !== 16'd4) $display("FAIL all4_fc: got %0d required 4", fc); else pass_cnt++;
        total_cnt++; if (b !== 1'b0) $display("FAIL all4_busy: got %b required 0", b); else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [7:0] tx, e_tx;
        logic [NUM_CH-1:0] a0, a1, e_ack, want;
        logic b;
        logic [15:0] fc;
        int win;
        do_reset();
        req = 4'b1001;
        req_data = '0;
        req_data[15:0]  = 16'hC0DE;
        req_data[63:48] = 16'h5A5A;
        for (int i = 0; i < 16; i++) begin
            model_step(req, req_data, e_tx, e_ack, win);
            send_byte(tx, a0, a1, b, fc);
            want = (i % 4 != 0) ? 4'b0000 : (((i / 4) % 2 == 0) ? 4'b0001 : 4'b1000);
            $display("fair byte %0d: tx=%h ack=%b", i, tx, a0);
            total_cnt++; if (tx !== e_tx) $display("FAIL fair_tx[%0d]: got %h required %h", i, tx, e_tx); else pass_cnt++;
            total_cnt++; if (a0 !== want) $display("FAIL fair_grant[%0d]: got %b required %b", i, a0, want); else pass_cnt++;
            total_cnt++; if (a1 !== 4'b0000) $display("FAIL fair_ack_width[%0d]: got %b required 0000", i, a1); else pass_cnt++;
        end
        req = '0;
    endtask

    task automatic test_reset_mid_payload();
        logic [7:0] tx, e_tx;
        logic [NUM_CH-1:0] a0, a1, e_ack;
        logic b;
        logic [15:0] fc;
        int win;
        do_reset();
        req = 4'b0010;
        req_data = '0;
        req_data[31:16] = 16'h9876;
        for (int i = 0; i < 2; i++) begin
            model_step(req, req_data, e_tx, e_ack, win);
            send_byte(tx, a0, a1, b, fc);
            if (win >= 0) req[win] = 1'b0;
            total_cnt++; if (tx !== e_tx) $display("FAIL midpay_pre_tx[%0d]: got %h required %h", i, tx, e_tx); else pass_cnt++;
        end
        #2;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (tx_data !== 8'h00) $display("FAIL midpay_tx: got %h required 00", tx_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midpay_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (frame_count !== 16'd0) $display("FAIL midpay_fc: got %0d required 0", frame_count); else pass_cnt++;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++; if (ack !== '0) $display("FAIL midpay_no_reack[%0d]: got %b required 0000", i, ack); else pass_cnt++;
        end
        req_data[47:32] = 16'h0F0F;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) req[2] = 1'b1;
            model_step(req, req_data, e_tx, e_ack, win);
            send_byte(tx, a0, a1, b, fc);
            if (win >= 0) req[win] = 1'b0;
            $display("midpay restart byte %0d: tx=%h ack=%b", i, tx, a0);
            total_cnt++; if (tx !== e_tx) $display("FAIL midpay_post_tx[%0d]: got %h required %h", i, tx, e_tx); else pass_cnt++;
            total_cnt++; if (a0 !== e_ack) $display("FAIL midpay_post_ack[%0d]: got %b required %b", i, a0, e_ack); else pass_cnt++;
        end
    endtask

    task automatic test_no_byte_sent();
        do_reset();
        req = 4'b0010;
        req_data[31:16] = 16'hAAAA;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total_cnt++; if (ack !== '0) $display("FAIL nobs_ack[%0d]: got %b required 0000", i, ack); else pass_cnt++;
            total_cnt++; if (tx_data !== 8'h00) $display("FAIL nobs_tx[%0d]: got %h required 00", i, tx_data); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL nobs_busy[%0d]: got %b required 0", i, busy); else pass_cnt++;
        end
        req = '0;
    endtask

    task automatic test_random();
        logic [7:0] tx, e_tx;
        logic [NUM_CH-1:0] a0, a1, e_ack;
        logic b;
        logic [15:0] fc;
        int win, gap, g;
        do_reset();
        req = '0;
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!req[c] && $urandom_range(0, 3) == 0) begin
                    req_data[c*W +: W] = W'($urandom);
                    req[c] = 1'b1;
                end
            end
            gap = $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) begin
                g = $urandom_range(0, NUM_CH - 1);
                @(negedge clk);
                if (!req[g] && $urandom_range(0, 1) == 0) begin
                    req[g] = 1'b1;
                    @(negedge clk);
                    req[g] = 1'b0;
                end
                total_cnt++; if (ack !== '0) $display("FAIL rand_gap_ack[%0d]: got %b required 0000", n, ack); else pass_cnt++;
            end
            model_step(req, req_data, e_tx, e_ack, win);
            send_byte(tx, a0, a1, b, fc);
            if (win >= 0) begin
                req[win] = 1'b0;
                req_data[win*W +: W] = W'($urandom);
            end
            $display("rand byte %0d: tx=%h ack=%b busy=%b fc=%0d", n, tx, a0, b, fc);
            total_cnt++; if (tx !== e_tx) $display("FAIL rand_tx[%0d]: got %h required %h", n, tx, e_tx); else pass_cnt++;
            total_cnt++; if (a0 !== e_ack) $display("FAIL rand_ack[%0d]: got %b required %b", n, a0, e_ack); else pass_cnt++;
            total_cnt++; if (a1 !== '0) $display("FAIL rand_ack_width[%0d]: got %b required 0000", n, a1); else pass_cnt++;
            total_cnt++; if (b !== m_in_frame) $display("FAIL rand_busy[%0d]: got %b required %b", n, b, m_in_frame); else pass_cnt++;
            total_cnt++; if (fc !== 16'(m_count)) $display("FAIL rand_fc[%0d]: got %0d required %0d", n, fc, 16'(m_count)); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_all_four();
        test_fairness();
        test_reset_mid_payload();
        test_no_byte_sent();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
